// File: rtl/clk_int_div_meas.sv
// Measures the period of sig_i in clk_i cycles and reports it as a divider value (period - 1).
// Define CLK_INT_DIV_MEAS_SYNC_EN to pass sig_i through a 2-flop synchronizer before edge detection.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | measurement disabled, counter/lock/valid held clear
// ARM   | waiting for the first sig_i rising edge to start counting
// MEAS  | counting clk_i cycles between rising edges, capturing each
module clk_int_div_meas #(
    parameter int DIV_VALUE_WIDTH = 32,
    parameter int LOCK_CNT_WIDTH  = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       sig_i,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    output logic                       lock_o,
    output logic                       timeout_o,
    output logic                       overrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    // One count below saturation: the next cycle without an edge lands on all-ones.
    localparam logic [DIV_VALUE_WIDTH-1:0] CNT_LAST = {{(DIV_VALUE_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [DIV_VALUE_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [LOCK_CNT_WIDTH-1:0]  LOCK_MAX = '1;

    state_t                     state;
    logic [DIV_VALUE_WIDTH-1:0] cnt;
    logic [LOCK_CNT_WIDTH-1:0]  lock_cnt;
    logic                       sig_s;
    logic                       sig_prev;
    logic                       sig_rise;

`ifdef CLK_INT_DIV_MEAS_SYNC_EN
    logic sig_meta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_meta <= 1'b0;
            sig_s    <= 1'b0;
        end else begin
            sig_meta <= sig_i;
            sig_s    <= sig_meta;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_s <= 1'b0;
        end else begin
            sig_s <= sig_i;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig_s;
        end
    end

    assign sig_rise = sig_s & ~sig_prev;
    assign lock_o   = (lock_cnt == LOCK_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            lock_cnt    <= '0;
            div_o       <= '0;
            div_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (!en_i) begin
                state       <= IDLE;
                cnt         <= '0;
                lock_cnt    <= '0;
                div_valid_o <= 1'b0;
                timeout_o   <= 1'b0;
            end else begin
                if (div_valid_o && div_ready_i) begin
                    div_valid_o <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    ARM: begin
                        if (sig_rise) begin
                            state     <= MEAS;
                            cnt       <= '0;
                            timeout_o <= 1'b0;
                        end
                    end
                    MEAS: begin
                        if (sig_rise) begin
                            cnt         <= '0;
                            div_o       <= cnt;
                            div_valid_o <= 1'b1;
                            // A same-cycle handshake consumes the old value, so no overrun then.
                            overrun_o   <= div_valid_o & ~div_ready_i;
                            if (cnt == div_o) begin
                                lock_cnt <= (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
                            end else begin
                                lock_cnt <= '0;
                            end
                        end else if (cnt == CNT_LAST) begin
                            cnt       <= CNT_MAX;
                            timeout_o <= 1'b1;
                            lock_cnt  <= '0;
                            state     <= ARM;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_int_div_meas.sv
// Self-checking bench for clk_int_div_meas (8-bit divider, 2-bit lock counter) in the default build.
// Expected outputs come from a timestamp-based model of edge spacing, handshake and lock streaks.
module tb_clk_int_div_meas;

    localparam int DW = 8;
    localparam int LW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b0;
    logic          sig_i = 1'b0;
    logic          div_ready_i = 1'b0;
    logic [DW-1:0] div_o;
    logic          div_valid_o;
    logic          lock_o;
    logic          timeout_o;
    logic          overrun_o;

    clk_int_div_meas #(
        .DIV_VALUE_WIDTH(DW),
        .LOCK_CNT_WIDTH (LW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .sig_i      (sig_i),
        .div_o      (div_o),
        .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i),
        .lock_o     (lock_o),
        .timeout_o  (timeout_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_seen  = 0;

    // Reference model: edge times and capture history rather than counters.
    int            cyc = 0;
    int            last_edge = 0;
    int            mode = 0;       // 0 disabled, 1 waiting for first edge, 2 measuring
    int            streak = 0;     // consecutive captures equal to their predecessor
    logic          s_d1 = 1'b0;
    logic          s_d2 = 1'b0;
    logic [DW-1:0] e_div = '0;
    logic          e_valid = 1'b0;
    logic          e_timeout = 1'b0;
    logic          e_overrun = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mode      = 0;
        streak    = 0;
        s_d1      = 1'b0;
        s_d2      = 1'b0;
        e_div     = '0;
        e_valid   = 1'b0;
        e_timeout = 1'b0;
        e_overrun = 1'b0;
    endtask

    task automatic model_update();
        logic          rise;
        logic          v_old;
        logic [DW-1:0] cap;
        cyc++;
        if (rst_i) begin
            model_reset();
            return;
        end
        rise      = s_d1 & ~s_d2;
        v_old     = e_valid;
        e_overrun = 1'b0;
        if (!en_i) begin
            mode      = 0;
            e_valid   = 1'b0;
            e_timeout = 1'b0;
            streak    = 0;
        end else begin
            if (v_old && div_ready_i) e_valid = 1'b0;
            if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (rise) begin
                    mode      = 2;
                    last_edge = cyc;
                    e_timeout = 1'b0;
                end
            end else if (rise) begin
                cap       = DW'(cyc - last_edge - 1);
                e_overrun = v_old && !div_ready_i;
                streak    = (cap == e_div) ? streak + 1 : 0;
                e_div     = cap;
                e_valid   = 1'b1;
                last_edge = cyc;
            end else if (cyc - last_edge == 255) begin
                e_timeout = 1'b1;
                streak    = 0;
                mode      = 1;
            end
        end
        s_d2 = s_d1;
        s_d1 = sig_i;
    endtask

    task automatic check_all();
        chk("div_o", 32'(div_o), 32'(e_div));
        chk("div_valid_o", 32'(div_valid_o), 32'(e_valid));
        chk("lock_o", 32'(lock_o), 32'(streak >= 3));
        chk("timeout_o", 32'(timeout_o), 32'(e_timeout));
        chk("overrun_o", 32'(overrun_o), 32'(e_overrun));
    endtask

    task automatic step(input logic s, input logic e, input logic r);
        sig_i       = s;
        en_i        = e;
        div_ready_i = r;
        @(posedge clk_i);
        model_update();
        #1;
        check_all();
        if (overrun_o === 1'b1) ov_seen++;
    endtask

    // rdy_mode: 0 = ready low, 1 = ready high, 2 = random per cycle
    task automatic run_period(input int t, input int n, input logic e, input int rdy_mode);
        logic r;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < t; c++) begin
                r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
                step(c < t / 2, e, r);
            end
        end
    endtask

    task automatic do_reset_pulse();
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        chk("rst_div_o", 32'(div_o), 32'd0);
        chk("rst_valid", 32'(div_valid_o), 32'd0);
        chk("rst_lock", 32'(lock_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        rst_i = 1'b0;
    endtask

    initial begin
        // Power-on reset
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        step(1'b0, 1'b1, 1'b1);

        // Period 4, ready high: captures of 3, lock after four captures
        run_period(4, 6, 1'b1, 1);
        chk("p4_div", 32'(div_o), 32'd3);
        chk("p4_lock", 32'(lock_o), 32'd1);

        // Period 5 warm-up, then two captures with ready low: one overrun, lock kept
        run_period(5, 5, 1'b1, 1);
        ov_seen = 0;
        run_period(5, 2, 1'b1, 0);
        chk("p5_overrun_count", 32'(ov_seen), 32'd1);
        chk("p5_div_held", 32'(div_o), 32'd4);
        chk("p5_valid_held", 32'(div_valid_o), 32'd1);
        chk("p5_lock", 32'(lock_o), 32'd1);
        run_period(5, 1, 1'b1, 1);

        // Period 6 then 8: lock drops on first 7, returns after three more
        run_period(6, 5, 1'b1, 1);
        chk("p6_lock", 32'(lock_o), 32'd1);
        run_period(8, 2, 1'b1, 1);
        chk("p8_first7_div", 32'(div_o), 32'd7);
        chk("p8_first7_lock", 32'(lock_o), 32'd0);
        run_period(8, 3, 1'b1, 1);
        chk("p8_relock", 32'(lock_o), 32'd1);

        // sig_i stuck low: timeout, then next edge re-arms without capture
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 1'b1);
        chk("to_timeout", 32'(timeout_o), 32'd1);
        chk("to_lock", 32'(lock_o), 32'd0);
        run_period(4, 1, 1'b1, 1);
        chk("to_cleared", 32'(timeout_o), 32'd0);
        chk("to_no_capture", 32'(div_valid_o), 32'd0);

        // Reset mid-period, then period 3: first capture on the second edge
        run_period(3, 2, 1'b1, 1);
        step(1'b1, 1'b1, 1'b1);
        do_reset_pulse();
        step(1'b0, 1'b1, 1'b1);
        run_period(3, 1, 1'b1, 1);
        chk("rst_no_capture", 32'(div_valid_o), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_first_div", 32'(div_o), 32'd2);
        chk("rst_first_valid", 32'(div_valid_o), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        run_period(3, 3, 1'b1, 1);

        // Disable with a pending value
        run_period(5, 3, 1'b1, 0);
        chk("dis_valid_before", 32'(div_valid_o), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("dis_valid", 32'(div_valid_o), 32'd0);
        chk("dis_lock", 32'(lock_o), 32'd0);
        chk("dis_timeout", 32'(timeout_o), 32'd0);
        run_period(5, 3, 1'b0, 0);
        chk("dis_no_capture", 32'(div_valid_o), 32'd0);
        step(1'b0, 1'b1, 1'b1);

        // Random periods (including the 2-cycle minimum) with random ready
        for (int i = 0; i < 150; i++) begin
            run_period($urandom_range(2, 10), 1, 1'b1, 2);
        end
        run_period(2, 6, 1'b1, 1);
        chk("p2_div", 32'(div_o), 32'd1);
        chk("p2_lock", 32'(lock_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_int_div_meas.md
CLK_INT_DIV_MEAS -- requirements
Module: clk_int_div_meas

Interface
REQ-001 SHALL have parameter DIV_VALUE_WIDTH, default 32: width of the counter and of the measured value.
REQ-002 SHALL have parameter LOCK_CNT_WIDTH, default 3: width of the saturating lock counter.
REQ-003 SHALL have port clk_i, input, 1 bit: sole clock.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en_i, input, 1 bit: measurement enable.
REQ-006 SHALL have port sig_i, input, 1 bit: divided clock or trigger under measurement.
REQ-007 SHALL have port div_o, output, DIV_VALUE_WIDTH bits: measured period minus 1, in clk_i cycles (same encoding as a divider's div value).
REQ-008 SHALL have port div_valid_o, output, 1 bit: div_o holds an unconsumed measurement.
REQ-009 SHALL have port div_ready_i, input, 1 bit: consumer accepts div_o.
REQ-010 SHALL have port lock_o, output, 1 bit: ratio stable.
REQ-011 SHALL have port timeout_o, output, 1 bit: no edge seen within counter range.
REQ-012 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when an unconsumed value is overwritten.

Function
REQ-013 SHALL detect a rising edge of sig_i as: sampled value 1 and previous sample 0.
REQ-014 SHALL implement FSM states IDLE, ARM and MEAS.
- IDLE -> ARM when en_i=1.
- ARM -> MEAS on the first edge.
- Any state -> IDLE when en_i=0 (counter, lock and valid cleared).
REQ-015 SHALL handle the period counter as follows:
- loads 0 on every edge cycle;
- otherwise increments by 1 while in MEAS;
- saturates at all-ones.
REQ-016 SHALL, on an edge in MEAS, capture the current count (edges T cycles apart give T-1) into div_o and set div_valid_o the next cycle.
REQ-017 SHALL hold div_o and div_valid_o stable until div_ready_i=1 while valid; the value is consumed on valid&ready.
REQ-018 SHALL, when a new capture coincides with a pending value and no ready, overwrite div_o, keep valid=1 and pulse overrun_o for 1 cycle.
REQ-019 SHALL, when a new capture coincides with valid&ready in the same cycle, load the new value, keep valid=1 and not pulse overrun_o.
REQ-020 SHALL handle the lock counter as follows:
- increments (saturating) when a capture equals the previous capture;
- clears to 0 when a capture differs;
- lock_o=1 iff the counter is all-ones.
REQ-021 SHALL, when the counter reaches all-ones in MEAS:
- set timeout_o=1;
- clear the lock counter;
- move to ARM;
- make no capture.
REQ-022 SHALL clear timeout_o on the next edge or when en_i=0.
REQ-023 SHALL set the minimum measurable period to 2 cycles (div_o=1); div 0 (sig_i = clk_i) is not measurable and ends in timeout.

Reset
REQ-024 SHALL, while rst_i=1, asynchronously force:
- FSM to IDLE;
- counter, lock counter and div_o to 0;
- div_valid_o, lock_o, timeout_o and overrun_o to 0;
- the edge-detect history to 0.
REQ-025 SHALL, when reset is asserted mid-measurement, discard the pending value; the first edge after release re-arms only and does not capture.

Configuration
REQ-026 SHALL, with macro CLK_INT_DIV_MEAS_SYNC_EN defined, pass sig_i through a 2-flop synchronizer before edge detection, so captures lag the sig_i edge by 3 cycles.
REQ-027 SHALL, without CLK_INT_DIV_MEAS_SYNC_EN, register sig_i once before edge detection (1-cycle lag); sig_i must then be synchronous to clk_i; measured values are identical in both builds.

Verification (DIV_VALUE_WIDTH=8, LOCK_CNT_WIDTH=2)
REQ-028 SHALL cover: en_i=1, sig_i period 4 cycles (50% duty), ready tied 1 -> div_o=3 per edge after the first; lock_o=1 after 4 captures.
REQ-029 SHALL cover: sig_i period 5, ready=0 for 2 edges -> div_o=4 held; overrun_o pulses once on the second capture; lock_o stays 1.
REQ-030 SHALL cover: period changes 6 -> 8 -> lock_o drops on the first div_o=7 capture and re-asserts after 3 further equal captures.
REQ-031 SHALL cover: sig_i held 0 after edges in MEAS -> timeout_o=1 after 255 count cycles; lock_o=0; FSM in ARM; next edge clears timeout and makes no capture.
REQ-032 SHALL cover: rst_i pulse mid-period, then period 3 -> all outputs 0 during reset; first post-reset capture is div_o=2, on the second edge.
REQ-033 SHALL cover: en_i deasserted with div_valid_o=1 -> valid, lock and timeout clear next cycle; no capture while en_i=0.
